// File: rtl/cic_pkg.sv
// Shared constants and helpers for the CIC decimator: accumulator sizing, shift clamp and
// signed saturation.
package cic_pkg;

  localparam int unsigned CIC_IN_WIDTH      = 18;
  localparam int unsigned CIC_STAGES        = 3;
  localparam int unsigned CIC_MAX_RATE_LOG2 = 8;

  // Bit growth of an N-stage CIC at rate R is N*log2(R), so this width never loses MSBs.
  function automatic int unsigned acc_width(input int unsigned in_w, input int unsigned stages,
                                            input int unsigned rate_log2);
    return in_w + stages * rate_log2;
  endfunction

  localparam int unsigned CIC_SHIFT_MAX =
      acc_width(CIC_IN_WIDTH, CIC_STAGES, CIC_MAX_RATE_LOG2) - CIC_IN_WIDTH;

  // Clip a signed value to the range of an n-bit two's-complement number.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] x,
                                                    input int unsigned n);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (n - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (n - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb stage: first difference with differential delay of one decimated sample.
module cic_comb_stage #(
  parameter int unsigned WIDTH = 42
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] delay_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      delay_q <= '0;
    end else if (en) begin
      delay_q <= din;
    end
  end

  assign dout = din - delay_q;

endmodule

// File: rtl/cic_decimator.sv
// Three-stage CIC decimator with programmable rate, arithmetic scaling and 18-bit saturation.
// Define CIC_ROUND_EN to round half up before the shift instead of truncating.
module cic_decimator
  import cic_pkg::*;
#(
  parameter int unsigned IN_WIDTH      = CIC_IN_WIDTH,
  parameter int unsigned STAGES        = CIC_STAGES,
  parameter int unsigned MAX_RATE_LOG2 = CIC_MAX_RATE_LOG2,
  parameter int unsigned ACC_WIDTH     = acc_width(IN_WIDTH, STAGES, MAX_RATE_LOG2)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clkEn,
  input  logic [MAX_RATE_LOG2-1:0] decRate,
  input  logic [5:0]               shift,
  input  logic [IN_WIDTH-1:0]      in,
  output logic [IN_WIDTH-1:0]      out,
  output logic                     syncOut
);

  localparam int unsigned SHIFT_MAX = ACC_WIDTH - IN_WIDTH;

  logic [ACC_WIDTH-1:0]     integ_q [STAGES];
  logic [MAX_RATE_LOG2-1:0] cnt_q;
  logic                     pending_q;
  logic                     wrap;
  logic [ACC_WIDTH-1:0]     comb_out;
  logic [5:0]               sh;
  logic signed [ACC_WIDTH:0] pre;
  logic signed [ACC_WIDTH:0] shifted;
  logic signed [63:0]       sat;
  logic [IN_WIDTH-1:0]      out_q;
  logic                     sync_q;

  // Integrators wrap modulo 2^ACC_WIDTH; the combs cancel the wrap exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) integ_q[k] <= '0;
    end else if (clkEn) begin
      integ_q[0] <= integ_q[0] + ACC_WIDTH'(signed'(in));
      for (int k = 1; k < STAGES; k++) integ_q[k] <= integ_q[k] + integ_q[k-1];
    end
  end

  // >= rather than == so a lowered decRate wraps on the next sample instead of stranding.
  assign wrap = clkEn && (cnt_q >= decRate);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      pending_q <= wrap;
      if (clkEn) cnt_q <= wrap ? '0 : cnt_q + 1'b1;
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_comb
    logic [ACC_WIDTH-1:0] x;
    logic [ACC_WIDTH-1:0] y;
    if (g == 0) begin : g_first
      assign x = integ_q[STAGES-1];
    end else begin : g_next
      assign x = g_comb[g-1].y;
    end
    cic_comb_stage #(
      .WIDTH(ACC_WIDTH)
    ) u_comb (
      .clk  (clk),
      .reset(reset),
      .en   (pending_q),
      .din  (x),
      .dout (y)
    );
  end

  assign comb_out = g_comb[STAGES-1].y;

  always_comb begin
    sh  = (shift > 6'(SHIFT_MAX)) ? 6'(SHIFT_MAX) : shift;
    pre = (ACC_WIDTH + 1)'(signed'(comb_out));
`ifdef CIC_ROUND_EN
    if (sh != 6'd0) pre = pre + $signed((ACC_WIDTH + 1)'(1) << (sh - 6'd1));
`endif
    shifted = pre >>> sh;
    sat     = sat_signed(64'(shifted), IN_WIDTH);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q  <= '0;
      sync_q <= 1'b0;
    end else begin
      sync_q <= pending_q;
      if (pending_q) out_q <= IN_WIDTH'(sat);
    end
  end

  assign out     = out_q;
  assign syncOut = sync_q;

endmodule

// File: tb/tb_cic_decimator.sv
// Directed self-checking bench for cic_decimator: DC gain, saturation, shift clamp, gapped
// enable, live rate change, mid-run reset and impulse rounding.
module tb_cic_decimator;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              clkEn;
  logic [7:0]        decRate;
  logic [5:0]        shift;
  logic signed [17:0] in_s;
  logic signed [17:0] out_s;
  logic              syncOut;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int en_div = 0;
  int n_sync, last_sync_cyc, period, sum_out, max_out, stray_updates;
  logic signed [17:0] last_out, prev_out;

  cic_decimator u_dut (
    .clk    (clk),
    .reset  (reset),
    .clkEn  (clkEn),
    .decRate(decRate),
    .shift  (shift),
    .in     (in_s),
    .out    (out_s),
    .syncOut(syncOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    n_sync        = 0;
    sum_out       = 0;
    max_out       = -(1 << 20);
    stray_updates = 0;
    period        = 0;
    last_sync_cyc = cyc;
  endtask

  // One clock: optional periodic enable, then sample 1 ns after the rising edge.
  task automatic step();
    if (en_div > 0) clkEn = (cyc % en_div == 0);
    prev_out = out_s;
    @(posedge clk);
    #1;
    cyc++;
    if (syncOut) begin
      n_sync++;
      period        = cyc - last_sync_cyc;
      last_sync_cyc = cyc;
      last_out      = out_s;
      sum_out      += int'(out_s);
      if (int'(out_s) > max_out) max_out = int'(out_s);
    end else if (out_s != prev_out) begin
      stray_updates++;
    end
  endtask

  task automatic wait_sync(input string tag, input int n, input int budget);
    int i = 0;
    while (n_sync < n && i < budget) begin
      step();
      i++;
    end
    check(tag, n_sync, n);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_stats();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    clkEn   = 1'b0;
    decRate = '0;
    shift   = '0;
    in_s    = '0;
    #1 reset = 1'b1;
    #1;
    check("reset_out", out_s, 0);
    check("reset_sync", syncOut, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    clear_stats();

    // DC settling: R=4, gain 64, shift 6 gives unity
    decRate = 8'd3;
    shift   = 6'd6;
    in_s    = 18'sd1000;
    en_div  = 1;
    for (int k = 1; k <= 6; k++) begin
      wait_sync("dc_sync", k, 20);
      if (k == 1) check("dc_first_latency", period, 5);
      else check("dc_period", period, 4);
      if (k >= 4) check("dc_out", last_out, 1000);
    end

    // Async reset right after a strobe, between edges
    #2 reset = 1'b1;
    #1;
    check("midrst_out", out_s, 0);
    check("midrst_sync", syncOut, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    clear_stats();
    wait_sync("midrst_resync", 1, 20);
    check("midrst_first_latency", period, 5);

    // Saturation, shift clamp, negative saturation at R=8
    do_reset();
    decRate = 8'd7;
    shift   = 6'd0;
    in_s    = 18'sd100000;
    wait_sync("satp_sync", 6, 100);
    check("sat_pos", last_out, 131071);
    shift = 6'd63;
    clear_stats();
    wait_sync("clamp_sync", 3, 60);
    check("shift_clamp", last_out, 3);
    shift = 6'd0;
    in_s  = -18'sd100000;
    clear_stats();
    wait_sync("satn_sync", 8, 100);
    check("sat_neg", last_out, -131072);

    // Gapped enable: one sample every 3 clocks, R=2, gain 8, shift 3
    do_reset();
    decRate = 8'd1;
    shift   = 6'd3;
    in_s    = 18'sd500;
    en_div  = 3;
    wait_sync("gap_sync", 6, 80);
    check("gap_out", last_out, 500);
    check("gap_period", period, 6);
    check("gap_no_stray_update", stray_updates, 0);

    // Live rate change with counter at 10
    do_reset();
    en_div  = 0;
    decRate = 8'd15;
    shift   = 6'd0;
    in_s    = '0;
    clkEn   = 1'b1;
    repeat (10) step();
    check("rc_no_sync_before", n_sync, 0);
    decRate = 8'd3;
    step();
    check("rc_wrap_edge", syncOut, 0);
    step();
    check("rc_sync_after_wrap", syncOut, 1);
    repeat (3) step();
    check("rc_count_mid", n_sync, 1);
    step();
    check("rc_next_sync", syncOut, 1);
    check("rc_period", period, 4);

    // Impulse at R=2, shift 0: decimated 1,3,3,1 response sums to 4, peak 3
    do_reset();
    decRate = 8'd1;
    shift   = 6'd0;
    clkEn   = 1'b1;
    in_s    = 18'sd1;
    step();
    in_s = '0;
    repeat (14) step();
    check("imp_sum", sum_out, 4);
    check("imp_max", max_out, 3);

    // Same impulse with shift 2: the 3 rounds to 1, the 1 to 0; truncation gives all zeros
    do_reset();
    shift = 6'd2;
    in_s  = 18'sd1;
    step();
    in_s = '0;
    repeat (14) step();
`ifdef CIC_ROUND_EN
    check("rnd_sum", sum_out, 1);
`else
    check("rnd_sum", sum_out, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
